// File: rtl/alu_exec_unit.sv
// alu_exec_unit
//   Handshaked, buffered execution unit around a WIDTH-bit add/sub/NAND/XOR ALU.
//   Requests are computed combinationally and written into a DEPTH-entry result
//   FIFO on accept; responses leave from the FIFO head over a valid/ready channel.
//
// Ports
//   clk, rst_n                  clock (rising edge), async active-low reset
//   req_valid/req_ready         request handshake (ready = FIFO not full)
//   req_op, req_a, req_b        opcode (00 ADD, 01 SUB, 10 NAND, 11 XOR), operands
//   rsp_valid/rsp_ready         response handshake (valid = FIFO not empty)
//   rsp_result, rsp_error,      FIFO head: result, signed overflow flag,
//   rsp_op                      echoed opcode
//   op_count, err_count         statistics counters
//
// Configuration
//   ALU_STATS_EN  when defined, op_count/err_count count accepted requests and
//                 accepted requests with error=1 (saturating). When undefined
//                 both outputs are tied to 0.
module alu_exec_unit #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_error,
    output logic [1:0]       rsp_op,
    output logic [CNT_W-1:0] op_count,
    output logic [CNT_W-1:0] err_count
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    // ALU opcodes
    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_NAND = 2'b10;
    localparam logic [1:0] OP_XOR  = 2'b11;

    logic [WIDTH-1:0] r_mem_result [DEPTH];
    logic             r_mem_error  [DEPTH];
    logic [1:0]       r_mem_op     [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic [WIDTH-1:0] w_result;
    logic             w_error;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic             w_push;
    logic             w_pop;

    // ------------------------------------------------------------------
    // Combinational ALU
    // ------------------------------------------------------------------
    assign w_sum  = req_a + req_b;
    assign w_diff = req_a - req_b;

    always_comb begin
        w_result = '0;
        w_error  = 1'b0;
        unique case (req_op)
            OP_ADD: begin
                w_result = w_sum;
                w_error  = (req_a[WIDTH-1] == req_b[WIDTH-1]) &&
                           (w_sum[WIDTH-1] != req_a[WIDTH-1]);
            end
            OP_SUB: begin
                w_result = w_diff;
                w_error  = (req_a[WIDTH-1] != req_b[WIDTH-1]) &&
                           (w_diff[WIDTH-1] != req_a[WIDTH-1]);
            end
            OP_NAND: w_result = ~(req_a & req_b);
            OP_XOR:  w_result = req_a ^ req_b;
            default: w_result = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Result FIFO
    // ------------------------------------------------------------------
    // Ready comes from registered occupancy only: a pop in the same cycle
    // does not free a slot for a push while full.
    assign req_ready = (r_count < FULL);
    assign rsp_valid = (r_count != '0);
    assign w_push    = req_valid & req_ready;
    assign w_pop     = rsp_valid & rsp_ready;

    assign rsp_result = r_mem_result[r_rd_ptr];
    assign rsp_error  = r_mem_error[r_rd_ptr];
    assign rsp_op     = r_mem_op[r_rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem_result[i] <= '0;
                r_mem_error[i]  <= 1'b0;
                r_mem_op[i]     <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem_result[r_wr_ptr] <= w_result;
                r_mem_error[r_wr_ptr]  <= w_error;
                r_mem_op[r_wr_ptr]     <= req_op;
                r_wr_ptr               <= (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + PW'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------
`ifdef ALU_STATS_EN
    logic [CNT_W-1:0] r_op_count;
    logic [CNT_W-1:0] r_err_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_count  <= '0;
            r_err_count <= '0;
        end else if (w_push) begin
            if (r_op_count != '1) begin
                r_op_count <= r_op_count + CNT_W'(1);
            end
            if (w_error && (r_err_count != '1)) begin
                r_err_count <= r_err_count + CNT_W'(1);
            end
        end
    end

    assign op_count  = r_op_count;
    assign err_count = r_err_count;
`else
    assign op_count  = '0;
    assign err_count = '0;
`endif

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
Handshaked, buffered execution unit wrapping the team's 4-bit add/sub/NAND/XOR ALU function.
- Accepts operation requests from an initiator (decode/test driver) over a valid/ready channel.
- Computes result plus overflow error and queues responses in a small result FIFO.
- Returns responses over a second valid/ready channel.
- Acts as the responder end of the ALU operation interface.

Parameters:
WIDTH, 4, operand/result width in bits (signed two's complement for error detection)
DEPTH, 2, result FIFO entries (power of 2, >=2)
CNT_W, 8, width of statistics counters (optional feature)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  unit can accept request this cycle
req_op  input  2  00 ADD, 01 SUB, 10 NAND, 11 XOR
req_a  input  WIDTH  operand In1
req_b  input  WIDTH  operand In2
rsp_valid  output  1  FIFO head holds valid response
rsp_ready  input  1  consumer accepts response
rsp_result  output  WIDTH  result at FIFO head
rsp_error  output  1  signed overflow flag at FIFO head
rsp_op  output  2  opcode echoed with the result
op_count  output  CNT_W  accepted-op counter (ALU_STATS_EN only, else 0)
err_count  output  CNT_W  error-response counter (ALU_STATS_EN only, else 0)

Behaviour:
- Reset (async, rst_n=0): FIFO count=0, read/write pointers=0, rsp_valid=0, rsp_result=0, rsp_error=0, rsp_op=0, counters=0; req_ready=1 immediately after rst_n rises.
- Reset asserted mid-operation: all queued responses are discarded; no partial response is emitted.
- Accept: req_valid & req_ready at a rising edge. Result is computed combinationally from req_*, then written to the FIFO at that edge.
- Latency: with FIFO empty, rsp_valid=1 in the cycle after accept (1-cycle latency). No combinational req->rsp path.
- req_ready = (count < DEPTH); it depends only on registered state, never on rsp_ready. A full FIFO blocks acceptance even when a pop occurs that cycle.
- Pop: rsp_valid & rsp_ready at a rising edge advances the read pointer.
- Simultaneous push and pop: count unchanged; both pointers advance; head updates in order.
- rsp_* are stable while rsp_valid=1 and rsp_ready=0.
- Pointers wrap modulo DEPTH. Empty when count=0, full when count=DEPTH. rsp_valid = (count != 0).
- Arithmetic: all results truncated to WIDTH.
  - ADD: a+b. error=1 iff a and b have the same sign and the result sign differs.
  - SUB: a-b. error=1 iff a and b have different signs and the result sign differs from a.
  - NAND: ~(a&b). error=0.
  - XOR: a^b. error=0.
- Responses are returned strictly in request order.

Optional Feature:
ALU_STATS_EN
- Defined:
  - op_count increments on each accepted request.
  - err_count increments on each accepted request whose computed error=1.
  - Both saturate at all-ones and clear only on reset.
- Not defined: counters are not instantiated; op_count and err_count are tied to 0. Port list is unchanged.

Test Plan:
- ADD a=4'h7, b=4'h1, rsp_ready=1 -> one cycle after accept: rsp_valid=1, rsp_result=4'h8, rsp_error=1, rsp_op=00.
- SUB a=4'h8, b=4'h1 -> rsp_result=4'h7, rsp_error=1. SUB a=4'h3, b=4'h5 -> rsp_result=4'hE, rsp_error=0.
- NAND a=4'hF, b=4'hF -> 4'h0, error=0. XOR a=4'hA, b=4'h5 -> 4'hF, error=0.
- Backpressure: rsp_ready=0; issue ADD 1+1, ADD 2+2, ADD 3+3 back-to-back.
  - After two accepts, req_ready=0 and the third request is held.
  - Raise rsp_ready: results 2, 4, 6 are returned in order.
  - The third request is accepted only after the first pop.
- Reset mid-operation: with 2 responses queued, pulse rst_n=0 asynchronously (between edges) -> rsp_valid=0 immediately; after release, req_ready=1 and no stale responses appear.
- With ALU_STATS_EN: 100 random ops including 5 known overflows -> op_count=100, err_count matches the model; with the macro undefined both outputs read 0.
